// File: rtl/motor_pwm_gen.sv
// Four-channel ESC pulse generator: frame timer, double-buffered throttles,
// arm/disarm sequencing and command-loss failsafe.
module motor_pwm_gen #(
  parameter int PERIOD         = 125000,
  parameter int MIN_PULSE      = 50000,
  parameter int STEP           = 50,
  parameter int THR_MAX        = 1000,
  parameter int ARM_FRAMES     = 200,
  parameter int TIMEOUT_FRAMES = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] thr_1,
  input  logic [10:0] thr_2,
  input  logic [10:0] thr_3,
  input  logic [10:0] thr_4,
  input  logic        arm,
  output logic        pwm_1,
  output logic        pwm_2,
  output logic        pwm_3,
  output logic        pwm_4,
  output logic        frame_start,
  output logic        armed,
  output logic        failsafe
);

  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int AW = $clog2(ARM_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
  localparam bit CFG_OK = (MIN_PULSE + THR_MAX * STEP) < PERIOD;
  localparam logic [CW-1:0] LAST  = CW'(PERIOD - 1);
  localparam logic [CW-1:0] MINP  = CW'(MIN_PULSE);
  localparam logic [CW-1:0] STEPW = CW'(STEP);
  localparam logic [10:0]   TMAX  = 11'(THR_MAX);

  typedef enum logic [1:0] {DISARMED, ARMING, ARMED, FAILSAFE} state_t;

  function automatic logic [10:0] sat_thr(input logic [10:0] t);
    return (t > TMAX) ? TMAX : t;
  endfunction

  // Saturated throttle keeps the sum below PERIOD, so CW bits never overflow.
  function automatic logic [CW-1:0] pulse_of(input logic [10:0] t);
    return MINP + CW'(t) * STEPW;
  endfunction

  logic [CW-1:0] cnt;
  logic [10:0]   thr_in   [4];
  logic [10:0]   pending  [4];
  logic [10:0]   active   [4];
  logic [10:0]   load_thr [4];
  logic [CW-1:0] pulse    [4];
  logic [3:0]    pwm_q;
  state_t        state, state_n;
  logic [AW-1:0] arm_cnt, arm_cnt_n;
  logic [TW-1:0] wd, wd_n;
  logic          acc_flag, accept, boundary, all_zero, armed_d, failsafe_d;

  assign thr_in[0] = thr_1;
  assign thr_in[1] = thr_2;
  assign thr_in[2] = thr_3;
  assign thr_in[3] = thr_4;
  assign accept    = cmd_valid && cmd_ready;
  assign boundary  = (cnt == LAST);

  // A command landing in the boundary cycle is folded into that load.
  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_thr[i] = accept ? sat_thr(thr_in[i]) : pending[i];
      pulse[i]    = (state == ARMED) ? pulse_of(active[i]) : MINP;
      if (load_thr[i] != 11'd0) all_zero = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DISARMED;
      arm_cnt <= '0;
      wd      <= '0;
    end else begin
      state   <= state_n;
      arm_cnt <= arm_cnt_n;
      wd      <= wd_n;
    end
  end

  always_comb begin
    state_n   = state;
    arm_cnt_n = arm_cnt;
    wd_n      = accept ? '0 : wd;
    if (boundary) begin
      case (state)
        DISARMED: if (arm) begin
          state_n   = ARMING;
          arm_cnt_n = '0;
        end
        ARMING: begin
          if (!arm) state_n = DISARMED;
          else if (!all_zero) arm_cnt_n = '0;
          else if (arm_cnt == AW'(ARM_FRAMES - 1)) begin
            state_n = ARMED;
            wd_n    = '0;
          end else arm_cnt_n = arm_cnt + 1'b1;
        end
        ARMED: begin
          if (!arm) state_n = DISARMED;
          else if (acc_flag || accept) wd_n = '0;
          else if (wd == TW'(TIMEOUT_FRAMES - 1)) state_n = FAILSAFE;
          else wd_n = wd + 1'b1;
        end
        FAILSAFE: if (!arm) state_n = DISARMED;
        default: state_n = DISARMED;
      endcase
    end
  end

  always_comb begin
    armed_d    = (state == ARMED);
    failsafe_d = (state == FAILSAFE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      cmd_ready   <= 1'b0;
      frame_start <= 1'b0;
      armed       <= 1'b0;
      failsafe    <= 1'b0;
      acc_flag    <= 1'b0;
      pwm_q       <= '0;
      for (int i = 0; i < 4; i++) begin
        pending[i] <= '0;
        active[i]  <= '0;
      end
    end else begin
      cnt         <= boundary ? '0 : cnt + 1'b1;
      cmd_ready   <= 1'b1;
      frame_start <= (cnt == '0);
      armed       <= armed_d;
      failsafe    <= failsafe_d;
      acc_flag    <= boundary ? 1'b0 : (acc_flag || accept);
      for (int i = 0; i < 4; i++) begin
        pwm_q[i] <= (cnt < pulse[i]);
        if (accept)   pending[i] <= sat_thr(thr_in[i]);
        if (boundary) active[i]  <= load_thr[i];
      end
    end
  end

  assign pwm_1 = pwm_q[0];
  assign pwm_2 = pwm_q[1];
  assign pwm_3 = pwm_q[2];
  assign pwm_4 = pwm_q[3];

  always @(posedge clk) if (!rst) assert (CFG_OK);

endmodule

// File: tb/tb_motor_pwm_gen.sv
// Bench for motor_pwm_gen: frame-level reference model, directed scenarios
// and a randomized soak, all outputs compared every cycle.
module tb_motor_pwm_gen;
  localparam int P = 200, MINP = 50, STEP = 1, TMAX = 100, ARMF = 2, TOF = 3;

  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, arm = 1'b0;
  logic [10:0] tv [4];
  logic [10:0] thr_1, thr_2, thr_3, thr_4;
  logic cmd_ready, pwm_1, pwm_2, pwm_3, pwm_4, frame_start, armed, failsafe;

  assign thr_1 = tv[0];
  assign thr_2 = tv[1];
  assign thr_3 = tv[2];
  assign thr_4 = tv[3];

  motor_pwm_gen #(.PERIOD(P), .MIN_PULSE(MINP), .STEP(STEP), .THR_MAX(TMAX),
                  .ARM_FRAMES(ARMF), .TIMEOUT_FRAMES(TOF)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .thr_1(thr_1), .thr_2(thr_2), .thr_3(thr_3), .thr_4(thr_4), .arm(arm),
    .pwm_1(pwm_1), .pwm_2(pwm_2), .pwm_3(pwm_3), .pwm_4(pwm_4),
    .frame_start(frame_start), .armed(armed), .failsafe(failsafe));

  always #5 clk = ~clk;

  // Model: state codes 0 disarmed, 1 arming, 2 armed, 3 failsafe.
  int m_pos, m_state, m_armcnt, m_wd;
  int m_pend [4];
  int m_act  [4];
  bit m_acc, m_ready, fs_seen;
  logic [7:0] exp_out;
  int checks = 0, errors = 0;
  int cur_len [4];
  int last_len [4];
  int gap, last_gap;

  task automatic model_reset();
    m_pos = 0; m_state = 0; m_armcnt = 0; m_wd = 0; m_acc = 0; m_ready = 0;
    for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_act[i] = 0; cur_len[i] = 0; end
    exp_out = '0; gap = 0;
  endtask

  task automatic model_step();
    bit zero;
    int pw;
    exp_out[7] = 1'b1;
    exp_out[6] = (m_pos == 0);
    exp_out[5] = (m_state == 2);
    exp_out[4] = (m_state == 3);
    for (int i = 0; i < 4; i++) begin
      pw = (m_state == 2) ? MINP + m_act[i] * STEP : MINP;
      exp_out[i] = (m_pos < pw);
    end
    if (cmd_valid && m_ready) begin
      for (int i = 0; i < 4; i++) m_pend[i] = (int'(tv[i]) > TMAX) ? TMAX : int'(tv[i]);
      m_acc = 1;
    end
    m_ready = 1;
    if (m_pos == P - 1) begin
      zero = 1;
      for (int i = 0; i < 4; i++) begin
        m_act[i] = m_pend[i];
        if (m_pend[i] != 0) zero = 0;
      end
      case (m_state)
        0: if (arm) begin m_state = 1; m_armcnt = 0; end
        1: if (!arm) m_state = 0;
           else if (!zero) m_armcnt = 0;
           else begin
             m_armcnt++;
             if (m_armcnt >= ARMF) begin m_state = 2; m_wd = 0; end
           end
        2: if (!arm) m_state = 0;
           else if (m_acc) m_wd = 0;
           else begin
             m_wd++;
             if (m_wd >= TOF) m_state = 3;
           end
        default: if (!arm) m_state = 0;
      endcase
      m_acc = 0;
      m_pos = 0;
    end else m_pos++;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic tick();
    logic [7:0] got;
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    got = {cmd_ready, frame_start, armed, failsafe, pwm_4, pwm_3, pwm_2, pwm_1};
    checks++;
    if (got !== exp_out) begin
      errors++;
      $display("FAIL outputs pos=%0d got=%b want=%b", m_pos, got, exp_out);
    end
    if (failsafe) fs_seen = 1;
    if (frame_start) begin
      last_gap = gap; gap = 0;
      for (int i = 0; i < 4; i++) begin last_len[i] = cur_len[i]; cur_len[i] = 0; end
    end
    gap++;
    if (pwm_1) cur_len[0]++;
    if (pwm_2) cur_len[1]++;
    if (pwm_3) cur_len[2]++;
    if (pwm_4) cur_len[3]++;
  endtask

  task automatic next_frame();
    int n = 0;
    do begin tick(); n++; end while (m_pos != 1 && n < 2 * P);
  endtask

  task automatic goto_pos(input int p);
    int n = 0;
    while (m_pos != p && n < 2 * P) begin tick(); n++; end
  endtask

  task automatic send(input int a, input int b, input int c, input int d);
    tv[0] = 11'(a); tv[1] = 11'(b); tv[2] = 11'(c); tv[3] = 11'(d);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_lens(input string name, input int a, input int b, input int c, input int d);
    chk({name, "_1"}, last_len[0], a);
    chk({name, "_2"}, last_len[1], b);
    chk({name, "_3"}, last_len[2], c);
    chk({name, "_4"}, last_len[3], d);
  endtask

  task automatic arm_up();
    int n = 0;
    arm = 1'b1;
    while (m_state != 2 && n < 10) begin
      goto_pos(60); send(0, 0, 0, 0); next_frame(); n++;
    end
    chk("arm_up_state", m_state, 2);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin tv[i] = '0; last_len[i] = 0; end
    last_gap = 0; fs_seen = 0;
    model_reset();
    repeat (3) tick();
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    rst = 1'b0;

    // Disarmed idle frames.
    repeat (3) next_frame();
    chk("idle_gap", last_gap, P);
    chk_lens("idle_len", 50, 50, 50, 50);
    chk("idle_ready", int'(cmd_ready), 1);
    chk("idle_armed", int'(armed), 0);

    // Arming with a restart caused by nonzero throttle.
    arm = 1'b1;
    next_frame();
    goto_pos(60); send(0, 0, 0, 0); next_frame();
    goto_pos(60); send(5, 0, 0, 0); next_frame();
    chk("arming_restart_a", int'(armed), 0);
    goto_pos(60); send(0, 0, 0, 0); next_frame();
    chk("arming_restart_b", int'(armed), 0);
    goto_pos(60); send(0, 0, 0, 0); next_frame();
    chk("armed_rise", int'(armed), 1);

    // Double-buffered updates.
    goto_pos(100); send(30, 100, 150, 0); next_frame();
    chk_lens("cur_frame", 50, 50, 50, 50);
    next_frame();
    chk_lens("next_frame", 80, 150, 150, 50);
    goto_pos(P - 1); send(10, 20, 30, 40);
    next_frame();
    chk_lens("pre_bnd", 80, 150, 150, 50);
    next_frame();
    chk_lens("bnd_cmd", 60, 70, 80, 90);

    // Command loss into failsafe, then disarm.
    next_frame();
    chk("wd_armed", int'(armed), 1);
    chk("wd_fs0", int'(failsafe), 0);
    next_frame();
    chk("fs_on", int'(failsafe), 1);
    chk("fs_armed", int'(armed), 0);
    goto_pos(50); send(90, 90, 90, 90);
    next_frame(); next_frame();
    chk_lens("fs_len", 50, 50, 50, 50);
    arm = 1'b0;
    next_frame();
    chk("fs_off", int'(failsafe), 0);

    // Disarm coinciding with timeout.
    arm_up();
    fs_seen = 0;
    next_frame(); next_frame();
    goto_pos(P - 5); arm = 1'b0;
    next_frame();
    chk("tie_armed", int'(armed), 0);
    next_frame();
    chk("tie_fs_seen", int'(fs_seen), 0);

    // Asynchronous reset mid-pulse.
    arm_up();
    goto_pos(60); send(60, 60, 60, 60); next_frame();
    goto_pos(20);
    chk("pre_rst_pwm", int'(pwm_1), 1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_pwm", int'({pwm_4, pwm_3, pwm_2, pwm_1}), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    arm = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    next_frame(); next_frame();
    chk_lens("post_rst", 50, 50, 50, 50);
    chk("post_rst_armed", int'(armed), 0);

    // Randomized soak.
    arm = 1'b1;
    for (int n = 0; n < 6000; n++) begin
      int sel;
      if ($urandom_range(0, 999) < 3) arm = ~arm;
      if ($urandom_range(0, 1999) == 0) arm = 1'b1;
      cmd_valid = (n < 3000) ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 399) == 0);
      sel = $urandom_range(0, 2);
      for (int i = 0; i < 4; i++)
        tv[i] = (sel == 0) ? 11'd0 : (sel == 1) ? 11'($urandom_range(0, 2047))
                                                : 11'($urandom_range(98, 102));
      tick();
    end
    cmd_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
